enc_gen: RTL and testbench

ENC_GEN -- requirements
Module: enc_gen

---
 rtl/enc_gen.sv | 145 ++++++++++++++
 tb/tb_enc_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enc_gen.sv
// ---------------------------------------------------------------------------
// enc_gen -- quadrature encoder signal generator
//
// Produces A/B quadrature outputs with an index pulse, tracking a
// quarter-step position (0 .. 4*P_PPR-1) and a signed revolution count.
// Each quarter-step is I_PERIOD clock cycles long (0 is treated as 1).
//
// Ports:
//   CLK       in   system clock, rising edge
//   I_ARM     in   asynchronous active-low reset
//   I_EN      in   run enable (high = generate, low = hold)
//   I_DIR     in   direction, 1 = forward (A leads B), 0 = reverse
//   I_PERIOD  in   [31:0] clock cycles per quarter-step
//   O_A       out  encoder channel A
//   O_B       out  encoder channel B
//   O_Z       out  index pulse, high while running at position 0
//   O_POS     out  [15:0] quarter-step position
//   O_REV     out  [31:0] signed revolution count
//   O_RUN     out  high while running
// ---------------------------------------------------------------------------
module enc_gen #(
    parameter int unsigned P_PPR = 1024
) (
    input  logic        CLK,
    input  logic        I_ARM,
    input  logic        I_EN,
    input  logic        I_DIR,
    input  logic [31:0] I_PERIOD,
    output logic        O_A,
    output logic        O_B,
    output logic        O_Z,
    output logic [15:0] O_POS,
    output logic [31:0] O_REV,
    output logic        O_RUN
);

    localparam int unsigned POS_MAX_I = 4 * P_PPR - 1;
    localparam logic [15:0] POS_MAX   = POS_MAX_I[15:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] per_q,   per_d;
    logic [15:0] pos_q,   pos_d;
    logic [31:0] rev_q,   rev_d;
    logic        run_q,   run_d;
    logic        z_q,     z_d;
    logic        a_q,     a_d;
    logic        b_q,     b_d;
    logic [31:0] per_eff;

    always_comb begin
        per_eff = (I_PERIOD == '0) ? 32'd1 : I_PERIOD;

        state_d = state_q;
        timer_d = timer_q;
        per_d   = per_q;
        pos_d   = pos_q;
        rev_d   = rev_q;

        case (state_q)
            ST_IDLE: begin
                if (I_EN) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    per_d   = per_eff;
                end
            end
            ST_RUN: begin
                if (!I_EN) begin
                    // Leaving RUN drops any partial count; the exit edge never steps.
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == per_q - 32'd1) begin
                    timer_d = '0;
                    per_d   = per_eff;
                    if (I_DIR) begin
                        if (pos_q == POS_MAX) begin
                            pos_d = '0;
                            rev_d = rev_q + 32'd1;
                        end else begin
                            pos_d = pos_q + 16'd1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_MAX;
                            rev_d = rev_q - 32'd1;
                        end else begin
                            pos_d = pos_q - 16'd1;
                        end
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Outputs are registered from next-state values so they change
        // exactly on the step edge and never glitch.
        run_d = (state_d == ST_RUN);
        z_d   = (state_d == ST_RUN) && (pos_d == '0);
        a_d   = pos_d[0] ^ pos_d[1];
        b_d   = pos_d[1];
    end

    always_ff @(posedge CLK or negedge I_ARM) begin
        if (!I_ARM) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            per_q   <= 32'd1;
            pos_q   <= '0;
            rev_q   <= '0;
            run_q   <= 1'b0;
            z_q     <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            pos_q   <= pos_d;
            rev_q   <= rev_d;
            run_q   <= run_d;
            z_q     <= z_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign O_A   = a_q;
    assign O_B   = b_q;
    assign O_Z   = z_q;
    assign O_POS = pos_q;
    assign O_REV = rev_q;
    assign O_RUN = run_q;

endmodule

// File: tb/tb_enc_gen.sv
module tb_enc_gen;

    localparam int unsigned PPR   = 2;
    localparam int unsigned NPOS  = 4 * PPR;

    logic        CLK = 1'b0;
    logic        I_ARM = 1'b0;
    logic        I_EN = 1'b0;
    logic        I_DIR = 1'b1;
    logic [31:0] I_PERIOD = 32'd4;
    logic        O_A, O_B, O_Z, O_RUN;
    logic [15:0] O_POS;
    logic [31:0] O_REV;

    int n_tot  = 0;
    int n_pass = 0;

    enc_gen #(.P_PPR(PPR)) dut (
        .CLK(CLK), .I_ARM(I_ARM), .I_EN(I_EN), .I_DIR(I_DIR), .I_PERIOD(I_PERIOD),
        .O_A(O_A), .O_B(O_B), .O_Z(O_Z), .O_POS(O_POS), .O_REV(O_REV), .O_RUN(O_RUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: absolute step deadlines ----------------
    longint      cyc   = 0;
    longint      m_due = 0;
    bit          m_run = 0;
    int unsigned m_pos = 0;
    logic [31:0] m_rev = '0;
    logic [1:0]  gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};  // {A,B} per pos%4

    function automatic longint eff(input logic [31:0] p);
        return (p == 0) ? 64'd1 : longint'(p);
    endfunction

    always @(posedge CLK or negedge I_ARM) begin
        if (!I_ARM) begin
            m_run = 0; m_pos = 0; m_rev = '0;
        end else begin
            cyc++;
            if (!m_run) begin
                if (I_EN) begin m_run = 1; m_due = cyc + eff(I_PERIOD); end
            end else if (!I_EN) begin
                m_run = 0;
            end else if (cyc == m_due) begin
                if (I_DIR) begin
                    if (m_pos == NPOS - 1) m_rev = m_rev + 1;
                    m_pos = (m_pos + 1) % NPOS;
                end else begin
                    if (m_pos == 0) m_rev = m_rev - 1;
                    m_pos = (m_pos + NPOS - 1) % NPOS;
                end
                m_due = cyc + eff(I_PERIOD);
            end
        end
    end

    logic [1:0] m_ab;
    always @(negedge CLK) begin
        m_ab = gray[m_pos % 4];
        check("pos", O_POS, m_pos);
        check("rev", O_REV, m_rev);
        check("A",   O_A,   m_ab[1]);
        check("B",   O_B,   m_ab[0]);
        check("Z",   O_Z,   (m_run && m_pos == 0) ? 1 : 0);
        check("run", O_RUN, m_run ? 1 : 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic drv_edge();
        @(posedge CLK); #3;
    endtask

    // Count rising edges until O_POS changes; sampled 1 time unit after each edge.
    task automatic wait_change(input int budget, output int n);
        logic [15:0] p0;
        bit done;
        p0 = O_POS; n = 0; done = 0;
        while (!done && n < budget) begin
            @(posedge CLK); #1; n++;
            if (O_POS != p0) done = 1;
        end
        if (!done) check("wait_change_timeout", 0, 1);
    endtask

    int n, zc;
    logic [15:0] p1;
    bit hit;

    initial begin
        // reset state
        repeat (2) drv_edge();
        check("rst_pos", O_POS, 0);
        check("rst_run", O_RUN, 0);
        I_ARM = 1'b1;

        // reverse wrap from reset, period 3
        drv_edge();
        I_DIR = 1'b0; I_PERIOD = 32'd3; I_EN = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        check("rw_pre_pos", O_POS, 0);
        @(posedge CLK); #1;
        check("rw_pos", O_POS, 7);
        check("rw_A", O_A, 0);
        check("rw_B", O_B, 1);
        check("rw_rev", O_REV, 32'hFFFF_FFFF);

        // forward run, period 4, after a fresh reset
        drv_edge(); I_ARM = 1'b0; I_EN = 1'b0;
        drv_edge(); I_ARM = 1'b1;
        check("rearm_rev", O_REV, 0);
        drv_edge(); I_DIR = 1'b1; I_PERIOD = 32'd4; I_EN = 1'b1;
        zc = 0;
        repeat (32) begin @(posedge CLK); #1; zc += O_Z; end
        check("fw_zcount", zc, 4);
        @(posedge CLK); #1;
        check("fw_rev", O_REV, 1);
        check("fw_pos", O_POS, 0);

        // direction flip mid-step at position 2
        wait_change(10, n);
        wait_change(10, n);
        check("flip_at2", O_POS, 2);
        drv_edge(); I_DIR = 1'b0;
        wait_change(10, n);
        check("flip_lat", n, 3);
        check("flip_pos", O_POS, 1);
        check("flip_A", O_A, 1);
        check("flip_B", O_B, 0);

        // pause two cycles before the next step, hold 10 cycles
        drv_edge(); I_EN = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        check("pause_run", O_RUN, 0);
        check("pause_z", O_Z, 0);
        check("pause_pos", O_POS, 1);
        repeat (8) drv_edge();
        I_EN = 1'b1;
        wait_change(10, n);
        check("resume_lat", n, 5);   // entry edge plus four cycles
        check("resume_pos", O_POS, 0);

        // period 0 -> every cycle, then 4 -> 8 mid-step
        drv_edge(); I_DIR = 1'b1; I_PERIOD = 32'd0;
        wait_change(10, n);
        wait_change(10, n);
        check("p0_lat_a", n, 1);
        wait_change(10, n);
        check("p0_lat_b", n, 1);
        drv_edge(); I_PERIOD = 32'd4;
        wait_change(10, n);
        check("p4_latch", n, 1);
        drv_edge(); I_PERIOD = 32'd8;
        wait_change(10, n);
        check("p4_kept", n, 3);
        wait_change(20, n);
        check("p8_next", n, 8);

        // reset mid-run at pos 5, rev 3
        drv_edge(); I_ARM = 1'b0;
        drv_edge(); I_ARM = 1'b1; I_DIR = 1'b1; I_PERIOD = 32'd0; I_EN = 1'b1;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge CLK); #1;
            if (O_POS == 5 && O_REV == 3) hit = 1;
        end
        check("rm_reached", hit, 1);
        I_ARM = 1'b0; #1;
        check("rm_pos", O_POS, 0);
        check("rm_rev", O_REV, 0);
        check("rm_A", O_A, 0);
        check("rm_B", O_B, 0);
        check("rm_z", O_Z, 0);
        check("rm_run", O_RUN, 0);
        drv_edge(); I_EN = 1'b0;
        drv_edge(); I_ARM = 1'b1;
        repeat (4) drv_edge();
        check("rm_idle_run", O_RUN, 0);
        check("rm_idle_pos", O_POS, 0);
        I_EN = 1'b1; I_PERIOD = 32'd2;
        wait_change(10, n);
        check("rm_first", n, 3);
        check("rm_first_pos", O_POS, 1);
        repeat (5) drv_edge();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
